// File: rtl/mix_engine_pkg.sv
// mix_engine_pkg: shared FSM state type and lane offsets used by the mixing round.
package mix_engine_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Lane distances used by the diffusion round (added lane, xor-source lane, subtract-source lane)
  localparam int PREV_OFS = 1;
  localparam int XOR_OFS  = 3;
  localparam int SUB_OFS  = 2;

endpackage

// File: rtl/mix_engine_if.sv
// mix_engine_if: valid/ready block handshake into and out of the mixing engine.
interface mix_engine_if #(
  parameter int LANES = 8,
  parameter int WIDTH = 32
);

  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*WIDTH-1:0] out_data;

  // Producer/consumer side (drives blocks in, takes results out)
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Engine side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/mix_engine_round.sv
// mix_round: one combinational add/xor/shift diffusion round over all lanes.
// Every lane term is taken from the pre-round state, so lanes update in parallel.
module mix_round
  import mix_engine_pkg::*;
#(
  parameter int LANES = 8,
  parameter int WIDTH = 32,
  parameter int RW    = 3
) (
  input  logic [LANES*WIDTH-1:0] state,
  input  logic [RW-1:0]          round,
  output logic [LANES*WIDTH-1:0] next
);

  localparam int SH = WIDTH / 2;

  logic [WIDTH-1:0] s [LANES];
  logic [WIDTH-1:0] t [LANES];
  logic [WIDTH-1:0] u [LANES];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int PREV_I = (i + LANES - PREV_OFS) % LANES;
    localparam int XOR_I  = (i + XOR_OFS) % LANES;
    localparam int SUB_I  = (i + SUB_OFS) % LANES;

    assign s[i] = state[i*WIDTH +: WIDTH];
    assign t[i] = s[i] + s[PREV_I] + WIDTH'(i);
    assign u[i] = t[i] ^ (t[XOR_I] << SH);
    assign next[i*WIDTH +: WIDTH] = u[i] - (u[SUB_I] >> (SH + 1)) + WIDTH'(round);
  end

endmodule

// File: rtl/mix_engine.sv
// mix_engine: handshaked multi-lane mixer applying ROUNDS diffusion rounds, one per clock.
// Optional feature macro: MIX_ENGINE_ACCUM_EN -- when defined, a load xors the incoming
// block into the retained state (chained mode); otherwise each block replaces the state.
module mix_engine
  import mix_engine_pkg::*;
#(
  parameter int LANES  = 8,
  parameter int WIDTH  = 32,
  parameter int ROUNDS = 4
) (
  input  logic         clk,
  input  logic         rst,
  mix_engine_if.slave  bus,
  output logic         busy
);

  localparam int CW = $clog2(ROUNDS + 1);

  state_t                 st;
  logic [LANES*WIDTH-1:0] state;
  logic [LANES*WIDTH-1:0] next_state;
  logic [CW-1:0]          cnt;
  logic                   in_ready_q;
  logic                   out_valid_q;
  logic                   busy_q;

  mix_round #(
    .LANES (LANES),
    .WIDTH (WIDTH),
    .RW    (CW)
  ) u_round (
    .state (state),
    .round (cnt),
    .next  (next_state)
  );

  // Control FSM: load a block, run the rounds, hold the result until the consumer takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= IDLE;
      state       <= '0;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (bus.in_valid) begin
`ifdef MIX_ENGINE_ACCUM_EN
            state <= state ^ bus.in_data;
`else
            state <= bus.in_data;
`endif
            cnt        <= '0;
            st         <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          state <= next_state;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(ROUNDS - 1)) begin
            st          <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            st          <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          st          <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = state;
  assign busy          = busy_q;

endmodule

// File: tb/tb_mix_engine.sv
// tb_mix_engine: self-checking bench for mix_engine with three configurations
// (8x32 with one round, 8x32 with four rounds, 4x16 with four rounds) against a
// lane-array reference model of the diffusion rounds.
module tb_mix_engine;

`ifdef MIX_ENGINE_ACCUM_EN
  localparam bit ACCUM = 1'b1;
`else
  localparam bit ACCUM = 1'b0;
`endif

  logic clk;
  logic rst;
  logic busy1, busyd, busys;

  int passed = 0;
  int total  = 0;

  // Reference chaining state per engine (only used in accumulate mode)
  logic [255:0] acc1, accd;
  logic [63:0]  accs;

  mix_engine_if #(.LANES(8), .WIDTH(32)) if1 ();
  mix_engine_if #(.LANES(8), .WIDTH(32)) ifd ();
  mix_engine_if #(.LANES(4), .WIDTH(16)) ifs ();

  mix_engine #(.LANES(8), .WIDTH(32), .ROUNDS(1)) dut1 (.clk(clk), .rst(rst), .bus(if1), .busy(busy1));
  mix_engine #(.LANES(8), .WIDTH(32), .ROUNDS(4)) dutd (.clk(clk), .rst(rst), .bus(ifd), .busy(busyd));
  mix_engine #(.LANES(4), .WIDTH(16), .ROUNDS(4)) duts (.clk(clk), .rst(rst), .bus(ifs), .busy(busys));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: lanes held as plain integers, each round computed from the old lanes
  function automatic logic [255:0] model_mix(input logic [255:0] blk, input int lanes,
                                             input int width, input int rounds);
    longint unsigned s [8];
    longint unsigned t [8];
    longint unsigned u [8];
    longint unsigned mask;
    logic [255:0]    res;
    int              sh;
    mask = (64'd1 << width) - 64'd1;
    sh   = width / 2;
    for (int i = 0; i < lanes; i++) s[i] = 64'(blk >> (i * width)) & mask;
    for (int r = 0; r < rounds; r++) begin
      for (int i = 0; i < lanes; i++)
        t[i] = (s[i] + s[(i + lanes - 1) % lanes] + longint'(i)) & mask;
      for (int i = 0; i < lanes; i++)
        u[i] = (t[i] ^ (t[(i + 3) % lanes] << sh)) & mask;
      for (int i = 0; i < lanes; i++)
        s[i] = (u[i] - (u[(i + 2) % lanes] >> (sh + 1)) + longint'(r)) & mask;
    end
    res = '0;
    for (int i = 0; i < lanes; i++) res = res | (256'(s[i]) << (i * width));
    return res;
  endfunction

  task automatic do_reset;
    rst = 1'b1;
    if1.in_valid = 1'b0; if1.in_data = '0; if1.out_ready = 1'b0;
    ifd.in_valid = 1'b0; ifd.in_data = '0; ifd.out_ready = 1'b0;
    ifs.in_valid = 1'b0; ifs.in_data = '0; ifs.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b0;
    acc1 = '0;
    accd = '0;
    accs = '0;
  endtask

  // Push one block through the 8x32 single-round engine; lat is -1 on timeout
  task automatic run_1(input logic [255:0] d, output logic [255:0] res, output int lat);
    if1.in_valid = 1'b1;
    if1.in_data  = d;
    @(posedge clk); #1;
    if1.in_valid = 1'b0;
    if1.in_data  = {8{$urandom}};
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (if1.out_valid) begin lat = c; break; end
    end
    res = if1.out_data;
    if (lat >= 0) begin
      if1.out_ready = 1'b1;
      @(posedge clk); #1;
      if1.out_ready = 1'b0;
    end
  endtask

  // Push one block through the 4x16 engine with input and output gaps
  task automatic run_s(input logic [63:0] d, input int gap_in, input int gap_out,
                       output logic [63:0] res, output int lat);
    repeat (gap_in) begin @(posedge clk); #1; end
    ifs.in_valid = 1'b1;
    ifs.in_data  = d;
    @(posedge clk); #1;
    ifs.in_valid = 1'b0;
    ifs.in_data  = {$urandom, $urandom};
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (ifs.out_valid) begin lat = c; break; end
    end
    res = ifs.out_data;
    if (lat >= 0) begin
      repeat (gap_out) begin @(posedge clk); #1; end
      ifs.out_ready = 1'b1;
      @(posedge clk); #1;
      ifs.out_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    do_reset;
    for (int c = 0; c < 10; c++) begin
      total++;
      if ({ifd.in_ready, ifd.out_valid, busyd} !== 3'b100) begin
        $display("[TB] FAIL reset_flags cycle %0d: got %b want 100", c, {ifd.in_ready, ifd.out_valid, busyd});
      end else passed++;
      total++;
      if (ifd.out_data !== 256'd0) begin
        $display("[TB] FAIL reset_data cycle %0d: got %h want 0", c, ifd.out_data);
      end else passed++;
      @(posedge clk); #1;
    end
    total++;
    if ({if1.in_ready, if1.out_valid, busy1, ifs.in_ready, ifs.out_valid, busys} !== 6'b100100) begin
      $display("[TB] FAIL reset_others: got %b want 100100",
               {if1.in_ready, if1.out_valid, busy1, ifs.in_ready, ifs.out_valid, busys});
    end else passed++;
  endtask

  task automatic test_zero_block;
    logic [255:0] res, exp;
    int lat;
    do_reset;
    exp  = model_mix(ACCUM ? (acc1 ^ 256'd0) : 256'd0, 8, 32, 1);
    acc1 = exp;
    run_1(256'd0, res, lat);
    total++;
    if (lat !== 1) $display("[TB] FAIL zero_latency: got %0d want 1", lat);
    else passed++;
    total++;
    if (res[31:0] !== 32'h0002FFFE) $display("[TB] FAIL zero_lane0: got %h want 0002fffe", res[31:0]);
    else passed++;
    total++;
    if (res[63:32] !== 32'h0003FFFE) $display("[TB] FAIL zero_lane1: got %h want 0003fffe", res[63:32]);
    else passed++;
    total++;
    if (res !== exp) $display("[TB] FAIL zero_block: got %h want %h", res, exp);
    else passed++;
  endtask

  task automatic test_back_pressure;
    logic [255:0] d, exp;
    int lat;
    do_reset;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
    exp  = model_mix(ACCUM ? (accd ^ d) : d, 8, 32, 4);
    accd = exp;
    ifd.in_valid = 1'b1;
    ifd.in_data  = d;
    @(posedge clk); #1;
    ifd.in_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (ifd.out_valid) begin lat = c; break; end
    end
    total++;
    if (lat !== 4) $display("[TB] FAIL bp_latency: got %0d want 4", lat);
    else passed++;
    for (int c = 0; c < 20; c++) begin
      ifd.in_valid = 1'($urandom_range(0, 1));
      for (int i = 0; i < 8; i++) ifd.in_data[i*32 +: 32] = $urandom;
      @(posedge clk); #1;
      total++;
      if ({ifd.out_valid, ifd.in_ready, busyd} !== 3'b101) begin
        $display("[TB] FAIL bp_flags cycle %0d: got %b want 101", c, {ifd.out_valid, ifd.in_ready, busyd});
      end else passed++;
      total++;
      if (ifd.out_data !== exp) $display("[TB] FAIL bp_data cycle %0d: got %h want %h", c, ifd.out_data, exp);
      else passed++;
    end
    ifd.in_valid  = 1'b0;
    ifd.out_ready = 1'b1;
    @(posedge clk); #1;
    ifd.out_ready = 1'b0;
    total++;
    if ({ifd.in_ready, ifd.out_valid, busyd} !== 3'b100) begin
      $display("[TB] FAIL bp_release: got %b want 100", {ifd.in_ready, ifd.out_valid, busyd});
    end else passed++;
  endtask

  task automatic test_random_blocks;
    logic [63:0] d, res, exp;
    int lat;
    do_reset;
    for (int b = 0; b < 200; b++) begin
      d    = {$urandom, $urandom};
      exp  = 64'(model_mix(256'(ACCUM ? (accs ^ d) : d), 4, 16, 4));
      accs = exp;
      run_s(d, $urandom_range(0, 3), $urandom_range(0, 3), res, lat);
      total++;
      if (res !== exp) $display("[TB] FAIL rand_data block %0d: got %h want %h", b, res, exp);
      else passed++;
      total++;
      if (lat !== 4) $display("[TB] FAIL rand_latency block %0d: got %0d want 4", b, lat);
      else passed++;
    end
  endtask

  task automatic test_mid_reset;
    logic [63:0] ra, rb, exp;
    int lat;
    do_reset;
    exp = 64'(model_mix(256'd0, 4, 16, 4));
    run_s(64'd0, 0, 0, ra, lat);
    total++;
    if (ra !== exp) $display("[TB] FAIL mid_clean: got %h want %h", ra, exp);
    else passed++;
    ifs.in_valid = 1'b1;
    ifs.in_data  = 64'd0;
    @(posedge clk); #1;
    ifs.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    ifs.out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ifs.out_ready = 1'b0;
    acc1 = '0;
    accd = '0;
    accs = '0;
    total++;
    if ({ifs.in_ready, ifs.out_valid, busys} !== 3'b100 || ifs.out_data !== 64'd0) begin
      $display("[TB] FAIL mid_reset: got flags %b data %h want 100 and 0",
               {ifs.in_ready, ifs.out_valid, busys}, ifs.out_data);
    end else passed++;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      total++;
      if (ifs.out_valid !== 1'b0) $display("[TB] FAIL mid_no_valid cycle %0d: got %b want 0", c, ifs.out_valid);
      else passed++;
    end
    run_s(64'd0, 0, 0, rb, lat);
    total++;
    if (rb !== exp) $display("[TB] FAIL mid_after: got %h want %h", rb, exp);
    else passed++;
    total++;
    if (lat !== 4) $display("[TB] FAIL mid_latency: got %0d want 4", lat);
    else passed++;
  endtask

  task automatic test_accum;
    logic [255:0] r1, r2, e1, e2;
    int lat;
    do_reset;
    e1 = model_mix(256'd0, 8, 32, 1);
    e2 = ACCUM ? model_mix(e1, 8, 32, 1) : e1;
    run_1(256'd0, r1, lat);
    run_1(256'd0, r2, lat);
    total++;
    if (r1 !== e1) $display("[TB] FAIL accum_first: got %h want %h", r1, e1);
    else passed++;
    total++;
    if (r2 !== e2) $display("[TB] FAIL accum_second: got %h want %h", r2, e2);
    else passed++;
    total++;
    if ((r1 !== r2) !== ACCUM) $display("[TB] FAIL accum_differ: got %b want %b", (r1 !== r2), ACCUM);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_zero_block;
    test_back_pressure;
    test_random_blocks;
    test_mid_reset;
    test_accum;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
